// File: rtl/sim_mon_pkg.sv
// sim_mon_pkg: shared state, result and watch-kind encodings for the simulation monitor
package sim_mon_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;
    typedef enum logic [1:0] {RES_NONE = 2'd0, RES_PASS = 2'd1, RES_FAIL = 2'd2, RES_TIMEOUT = 2'd3} result_e;
    typedef enum logic [1:0] {KIND_OFF = 2'd0, KIND_PASS = 2'd1, KIND_FAIL = 2'd2} kind_e;
    function automatic int idx_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sim_monitor_if.sv
// sim_monitor_if: config, retire and status signals of the simulation monitor
interface sim_monitor_if import sim_mon_pkg::*; #(
    parameter int XLEN = 32,
    parameter int LANES = 2,
    parameter int N_WATCH = 4,
    parameter int CNT_W = 48
) ();
    localparam int IW = idx_w(N_WATCH);
    logic cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [XLEN-1:0] cfg_addr;
    logic [1:0] cfg_kind;
    logic arm;
    logic [CNT_W-1:0] timeout_lim;
    logic [LANES-1:0] ret_v;
    logic [LANES*XLEN-1:0] ret_pc;
    logic [1:0] state;
    logic done;
    logic [1:0] result;
    logic [IW-1:0] hit_idx;
    logic [XLEN-1:0] hit_pc;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] cycle_cnt;
    modport master (
        output cfg_we, cfg_idx, cfg_addr, cfg_kind, arm, timeout_lim, ret_v, ret_pc,
        input state, done, result, hit_idx, hit_pc, retired_cnt, cycle_cnt
    );
    modport slave (
        input cfg_we, cfg_idx, cfg_addr, cfg_kind, arm, timeout_lim, ret_v, ret_pc,
        output state, done, result, hit_idx, hit_pc, retired_cnt, cycle_cnt
    );
endinterface

// File: rtl/sim_mon_match.sv
// sim_mon_match: compares one retired PC against all active watch entries, lowest index wins
module sim_mon_match import sim_mon_pkg::*; #(
    parameter int XLEN = 32,
    parameter int N_WATCH = 4,
    localparam int IW = idx_w(N_WATCH)
) (
    input logic [XLEN-1:0] pc,
    input logic [N_WATCH-1:0][XLEN-1:0] addrs,
    input logic [N_WATCH-1:0][1:0] kinds,
    output logic hit,
    output logic [IW-1:0] idx,
    output logic [1:0] kind
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        kind = KIND_OFF;
        for (int i = N_WATCH - 1; i >= 0; i--) begin
            if (kinds[i] != KIND_OFF && addrs[i] == pc) begin
                hit = 1'b1;
                idx = IW'(i);
                kind = kinds[i];
            end
        end
    end
endmodule

// File: rtl/sim_monitor.sv
// sim_monitor: watches retired PCs for pass/fail addresses, counts cycles and retires, flags timeout
module sim_monitor import sim_mon_pkg::*; #(
    parameter int XLEN = 32,
    parameter int LANES = 2,
    parameter int N_WATCH = 4,
    parameter int CNT_W = 48
) (
    input logic clk,
    input logic reset,
    sim_monitor_if.slave bus
);
    localparam int IW = idx_w(N_WATCH);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;
    logic [1:0] state;
    logic done;
    logic [1:0] result;
    logic [IW-1:0] hit_idx;
    logic [XLEN-1:0] hit_pc;
    logic [CNT_W-1:0] retired_cnt, cycle_cnt;
    logic [N_WATCH-1:0][XLEN-1:0] addrs;
    logic [N_WATCH-1:0][1:0] kinds;
    logic [LANES-1:0] m_hit;
    logic [IW-1:0] m_idx [LANES];
    logic [1:0] m_kind [LANES];
    logic hit;
    logic [IW-1:0] h_idx;
    logic [1:0] h_kind;
    logic [XLEN-1:0] h_pc;
    logic [2:0] n_ret;
    logic [CNT_W:0] ret_sum;
    logic [CNT_W-1:0] ret_next, cyc_next;
    logic timeout_hit, cfg_ok;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sim_mon_match #(.XLEN(XLEN), .N_WATCH(N_WATCH)) u_match (
            .pc(bus.ret_pc[l*XLEN +: XLEN]),
            .addrs(addrs),
            .kinds(kinds),
            .hit(m_hit[l]),
            .idx(m_idx[l]),
            .kind(m_kind[l])
        );
    end
    // retires beyond the first hitting lane belong to code after the end marker and are not counted
    always_comb begin
        hit = 1'b0;
        h_idx = '0;
        h_kind = KIND_OFF;
        h_pc = '0;
        n_ret = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!hit) begin
                n_ret = n_ret + 3'(bus.ret_v[i]);
                if (bus.ret_v[i] && m_hit[i]) begin
                    hit = 1'b1;
                    h_idx = m_idx[i];
                    h_kind = m_kind[i];
                    h_pc = bus.ret_pc[i*XLEN +: XLEN];
                end
            end
        end
    end
    assign ret_sum = {1'b0, retired_cnt} + (CNT_W+1)'(n_ret);
    assign ret_next = ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
    assign cyc_next = &cycle_cnt ? cycle_cnt : cycle_cnt + CNT_W'(1);
    assign timeout_hit = bus.timeout_lim != '0 && cycle_cnt == bus.timeout_lim - CNT_W'(1);
    assign cfg_ok = bus.cfg_we && state != S_RUN;
    always_ff @(posedge clk) begin
        if (cfg_ok && !reset) addrs[bus.cfg_idx] <= bus.cfg_addr;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) kinds <= '0;
        else if (cfg_ok) kinds[bus.cfg_idx] <= bus.cfg_kind;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            done <= 1'b0;
            result <= RES_NONE;
            hit_idx <= '0;
            hit_pc <= '0;
            retired_cnt <= '0;
            cycle_cnt <= '0;
        end else if (state == S_RUN) begin
            cycle_cnt <= cyc_next;
            retired_cnt <= ret_next;
            if (hit) begin
                state <= S_DONE;
                done <= 1'b1;
                result <= h_kind;
                hit_idx <= h_idx;
                hit_pc <= h_pc;
            end else if (timeout_hit) begin
                state <= S_DONE;
                done <= 1'b1;
                result <= RES_TIMEOUT;
            end
        end else if (bus.arm) begin
            state <= S_RUN;
            done <= 1'b0;
            result <= RES_NONE;
            hit_idx <= '0;
            hit_pc <= '0;
            retired_cnt <= '0;
            cycle_cnt <= '0;
        end
    end
    assign bus.state = state;
    assign bus.done = done;
    assign bus.result = result;
    assign bus.hit_idx = hit_idx;
    assign bus.hit_pc = hit_pc;
    assign bus.retired_cnt = retired_cnt;
    assign bus.cycle_cnt = cycle_cnt;
endmodule

// File: tb/tb_sim_monitor.sv
// tb_sim_monitor: scoreboard bench for sim_monitor; expected end-of-run status queued at stimulus time
module tb_sim_monitor;
    localparam int XLEN = 32;
    localparam int LANES = 2;
    localparam int N_WATCH = 4;
    localparam int CNT_W = 48;
    typedef struct packed {
        logic [1:0] res;
        logic [1:0] idx;
        logic [31:0] pc;
        logic [47:0] ret;
        logic [47:0] cyc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    always #5 clk = ~clk;
    sim_monitor_if #(.XLEN(XLEN), .LANES(LANES), .N_WATCH(N_WATCH), .CNT_W(CNT_W)) bus ();
    sim_monitor_if #(.XLEN(XLEN), .LANES(LANES), .N_WATCH(N_WATCH), .CNT_W(4)) sbus ();
    sim_monitor #(.XLEN(XLEN), .LANES(LANES), .N_WATCH(N_WATCH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    sim_monitor #(.XLEN(XLEN), .LANES(LANES), .N_WATCH(N_WATCH), .CNT_W(4)) sdut (
        .clk(clk), .reset(reset), .bus(sbus)
    );
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [1:0] idx, input logic [31:0] addr, input logic [1:0] kind);
        bus.cfg_we = 1'b1;
        bus.cfg_idx = idx;
        bus.cfg_addr = addr;
        bus.cfg_kind = kind;
        cyc();
        bus.cfg_we = 1'b0;
    endtask
    task automatic arm_run();
        bus.arm = 1'b1;
        cyc();
        bus.arm = 1'b0;
    endtask
    task automatic retire(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        bus.ret_v = v;
        bus.ret_pc = {pc1, pc0};
        cyc();
        bus.ret_v = '0;
    endtask
    task automatic wait_done(output bit ok);
        for (int i = 0; i < 64 && bus.done !== 1'b1; i++) cyc();
        ok = bus.done === 1'b1;
    endtask
    task automatic test_reset();
        logic [135:0] o;
        reset = 1'b1;
        repeat (2) cyc();
        o = {bus.state, bus.done, bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt, 1'b0};
        checks++; if (o !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", o); end
        checks++; if (sbus.retired_cnt !== 4'd0 || sbus.state !== 2'd0) begin errors++; $display("FAIL reset_sat got %0d/%0d exp 0/0", sbus.retired_cnt, sbus.state); end
        reset = 1'b0;
        cyc();
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL idle_after_reset got %0d exp 0", bus.state); end
    endtask
    task automatic test_pass_hit();
        bit ok;
        exp_t e, o;
        wr(2'd0, 32'h8000_0044, 2'b01);
        arm_run();
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL arm_state got %0d exp 1", bus.state); end
        repeat (9) cyc();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL pass_early got %b exp 0", bus.done); end
        sb.push_back('{2'b01, 2'd0, 32'h8000_0044, 48'd1, 48'd10});
        retire(2'b10, 32'h0, 32'h8000_0044);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL pass_latency got %b exp 1", bus.done); end
        wait_done(ok);
        e = sb.pop_front();
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL pass_hit got %h exp %h", o, e); end
        bus.ret_v = 2'b11;
        bus.ret_pc = {32'h8000_0044, 32'h8000_0044};
        repeat (2) cyc();
        bus.ret_v = '0;
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (o !== e || bus.state !== 2'd2) begin errors++; $display("FAIL done_hold got %h st %0d exp %h st 2", o, bus.state, e); end
    endtask
    task automatic test_priority();
        bit ok;
        exp_t e, o;
        wr(2'd1, 32'h100, 2'b10);
        wr(2'd2, 32'h200, 2'b01);
        arm_run();
        sb.push_back('{2'b01, 2'd2, 32'h200, 48'd1, 48'd1});
        retire(2'b11, 32'h200, 32'h100);
        wait_done(ok);
        e = sb.pop_front();
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL lane_priority got %h exp %h", o, e); end
        arm_run();
        sb.push_back('{2'b10, 2'd1, 32'h100, 48'd2, 48'd1});
        retire(2'b11, 32'h999, 32'h100);
        wait_done(ok);
        e = sb.pop_front();
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL lane1_hit got %h exp %h", o, e); end
        wr(2'd3, 32'h100, 2'b01);
        arm_run();
        sb.push_back('{2'b10, 2'd1, 32'h100, 48'd1, 48'd1});
        retire(2'b01, 32'h100, 32'h0);
        wait_done(ok);
        e = sb.pop_front();
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL index_priority got %h exp %h", o, e); end
        wr(2'd3, 32'h0, 2'b00);
    endtask
    task automatic test_timeout();
        bit ok;
        exp_t e, o;
        bus.timeout_lim = 48'd5;
        arm_run();
        sb.push_back('{2'b11, 2'd0, 32'h0, 48'd0, 48'd5});
        repeat (4) cyc();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", bus.done); end
        cyc();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL timeout_exact got %b exp 1", bus.done); end
        wait_done(ok);
        e = sb.pop_front();
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL timeout got %h exp %h", o, e); end
        arm_run();
        sb.push_back('{2'b01, 2'd2, 32'h200, 48'd1, 48'd5});
        repeat (4) cyc();
        retire(2'b01, 32'h200, 32'h0);
        wait_done(ok);
        e = sb.pop_front();
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL timeout_vs_hit got %h exp %h", o, e); end
        bus.timeout_lim = '0;
    endtask
    task automatic test_cfg_lockout();
        bit ok;
        exp_t e, o;
        arm_run();
        wr(2'd3, 32'h300, 2'b10);
        retire(2'b01, 32'h300, 32'h0);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL cfg_in_run got %b exp 0", bus.done); end
        sb.push_back('{2'b01, 2'd2, 32'h200, 48'd2, 48'd3});
        retire(2'b01, 32'h200, 32'h0);
        wait_done(ok);
        e = sb.pop_front();
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL lockout_end got %h exp %h", o, e); end
        wr(2'd3, 32'h300, 2'b10);
        arm_run();
        sb.push_back('{2'b10, 2'd3, 32'h300, 48'd1, 48'd1});
        retire(2'b01, 32'h300, 32'h0);
        wait_done(ok);
        e = sb.pop_front();
        o = {bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt};
        checks++; if (!ok || o !== e) begin errors++; $display("FAIL cfg_in_done got %h exp %h", o, e); end
    endtask
    task automatic test_reset_mid_run();
        logic [135:0] o;
        arm_run();
        repeat (3) retire(2'b11, 32'h1, 32'h2);
        retire(2'b01, 32'h3, 32'h0);
        checks++; if (bus.retired_cnt !== 48'd7) begin errors++; $display("FAIL pre_reset_retired got %0d exp 7", bus.retired_cnt); end
        #2 reset = 1'b1;
        #1;
        o = {bus.state, bus.done, bus.result, bus.hit_idx, bus.hit_pc, bus.retired_cnt, bus.cycle_cnt, 1'b0};
        checks++; if (o !== '0) begin errors++; $display("FAIL async_reset got %h exp 0", o); end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) cyc();
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL no_rearm got %0d exp 0", bus.state); end
        arm_run();
        retire(2'b11, 32'h200, 32'h8000_0044);
        retire(2'b11, 32'h100, 32'h300);
        checks++; if (bus.done !== 1'b0 || bus.state !== 2'd1) begin errors++; $display("FAIL kinds_cleared got %b/%0d exp 0/1", bus.done, bus.state); end
        checks++; if (bus.retired_cnt !== 48'd4) begin errors++; $display("FAIL post_reset_retired got %0d exp 4", bus.retired_cnt); end
    endtask
    task automatic test_saturation();
        sbus.arm = 1'b1;
        cyc();
        sbus.arm = 1'b0;
        sbus.ret_v = 2'b11;
        repeat (10) cyc();
        checks++; if (sbus.retired_cnt !== 4'd15) begin errors++; $display("FAIL sat_retired got %0d exp 15", sbus.retired_cnt); end
        checks++; if (sbus.cycle_cnt !== 4'd10) begin errors++; $display("FAIL sat_cycles10 got %0d exp 10", sbus.cycle_cnt); end
        repeat (10) cyc();
        sbus.ret_v = '0;
        checks++; if (sbus.cycle_cnt !== 4'd15 || sbus.retired_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d/%0d exp 15/15", sbus.cycle_cnt, sbus.retired_cnt); end
    endtask
    initial begin
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_addr = '0;
        bus.cfg_kind = '0;
        bus.arm = 1'b0;
        bus.timeout_lim = '0;
        bus.ret_v = '0;
        bus.ret_pc = '0;
        sbus.cfg_we = 1'b0;
        sbus.cfg_idx = '0;
        sbus.cfg_addr = '0;
        sbus.cfg_kind = '0;
        sbus.arm = 1'b0;
        sbus.timeout_lim = '0;
        sbus.ret_v = '0;
        sbus.ret_pc = '0;
        test_reset();
        test_pass_hit();
        test_priority();
        test_timeout();
        test_cfg_lockout();
        test_reset_mid_run();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
